// File: rtl/seq_detect_param.sv
// Runtime-loadable serial sequence detector with overlap control and saturating match counter.
// Optional per-bit compare mask enabled by defining SEQ_DETECT_MASK_EN.
module seq_detect_param #(
  parameter int                 MAX_LEN = 8,
  parameter int                 LEN_W   = $clog2(MAX_LEN + 1),
  parameter int                 CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(8'b0000_1011),
  parameter int                 DEF_LEN = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               din,
  input  logic               din_valid,
  input  logic               overlap,
  input  logic               pat_load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LEN_W-1:0]   len_in,
`ifdef SEQ_DETECT_MASK_EN
  input  logic [MAX_LEN-1:0] pat_mask_in,
`endif
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy
);

  typedef enum logic {PRIME, ARMED} state_e;

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d, hist_q, hist_d;
  logic [LEN_W-1:0]   len_q, len_d, fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               match_q, match_d, busy_q;

  logic               acc, hit;
  logic [MAX_LEN-1:0] hist_nx, len_mask, cmp_mask;
  logic [LEN_W-1:0]   fill_nx, len_clamp;

`ifdef SEQ_DETECT_MASK_EN
  logic [MAX_LEN-1:0] mask_q, mask_d;
`endif

  always_comb begin
    // a load consumes the cycle, so a same-cycle data bit is dropped
    acc     = din_valid & ~pat_load;
    hist_nx = {hist_q[MAX_LEN-2:0], din};
    fill_nx = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);

    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) len_mask[i] = (LEN_W'(i) < len_q);
`ifdef SEQ_DETECT_MASK_EN
    cmp_mask = len_mask & mask_q;
`else
    cmp_mask = len_mask;
`endif
    hit = acc && (fill_nx >= len_q) && (((hist_nx ^ pat_q) & cmp_mask) == '0);

    if (len_in <= LEN_W'(1))             len_clamp = LEN_W'(1);
    else if (len_in > LEN_W'(MAX_LEN))   len_clamp = LEN_W'(MAX_LEN);
    else                                 len_clamp = len_in;
  end

  always_comb begin
    pat_d   = pat_q;
    len_d   = len_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    state_d = state_q;
    match_d = 1'b0;
    cnt_d   = cnt_q;
`ifdef SEQ_DETECT_MASK_EN
    mask_d  = mask_q;
`endif

    if (pat_load) begin
      pat_d   = pat_in;
      len_d   = len_clamp;
      hist_d  = '0;
      fill_d  = '0;
      state_d = PRIME;
`ifdef SEQ_DETECT_MASK_EN
      mask_d  = pat_mask_in;
`endif
    end else if (acc) begin
      hist_d  = hist_nx;
      fill_d  = fill_nx;
      state_d = (fill_nx >= len_q) ? ARMED : PRIME;
      match_d = hit;
      // non-overlapping: the completing bit must not seed the next match
      if (hit && !overlap) begin
        fill_d  = '0;
        state_d = PRIME;
      end
    end

    if (cnt_clr)                   cnt_d = '0;
    else if (hit && cnt_q != '1)   cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pat_q   <= DEF_PAT;
      len_q   <= LEN_W'(DEF_LEN);
      hist_q  <= '0;
      fill_q  <= '0;
      state_q <= PRIME;
      match_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
`ifdef SEQ_DETECT_MASK_EN
      mask_q  <= '1;
`endif
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      state_q <= state_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == PRIME);
`ifdef SEQ_DETECT_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign busy      = busy_q;

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised serial bit-sequence detector, the successor to the fixed 4-bit "1011" detector FSM. Pattern and length are runtime-loadable up to MAX_LEN bits. Supports overlapping and non-overlapping detection and keeps a saturating match counter. Sits on serial input streams (UART/SPI bit taps, sync-word search) and drives a registered match pulse to downstream control logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
LEN_W, $clog2(MAX_LEN+1), width of length fields
CNT_W, 8, match counter width
DEF_PAT, 8'b0000_1011, pattern after reset, right-aligned; bits above DEF_LEN ignored
DEF_LEN, 4, pattern length after reset

Ports:
clk  input  1  clock, rising edge
rstn  input  1  reset, asynchronous, active-low
din  input  1  serial data bit
din_valid  input  1  din sampled only when high
overlap  input  1  1 = overlapping detection, 0 = non-overlapping
pat_load  input  1  load pat_in/len_in this cycle
pat_in  input  MAX_LEN  new pattern, right-aligned; first-received bit at pat_in[len-1]
len_in  input  LEN_W  new pattern length
cnt_clr  input  1  synchronous clear of match_cnt
match  output  1  one-cycle pulse, cycle after the completing bit
match_cnt  output  CNT_W  saturating count of matches
busy  output  1  high while fill < length (detector still priming)

Behaviour:
- Reset (async, rstn low): pat=DEF_PAT, len=DEF_LEN, hist=0, fill=0, match=0, match_cnt=0, state=PRIME, busy=1.
- History: on accepted bit, hist <= {hist[MAX_LEN-2:0], din}; hist[0] = newest bit. fill counts valid history bits and saturates at MAX_LEN.
- Compare: hist_next[len-1:0] == pat[len-1:0], with fill_next >= len. Bits above len are ignored.
- State machine (2 states):
  - PRIME: fill < len; match never asserted. Moves to ARMED when fill_next >= len.
  - ARMED: compare active on each accepted bit.
- Match: when the compare is true in ARMED on an accepted bit, match=1 on the next cycle for exactly one cycle. Latency is 1 clk from the edge that samples the completing bit.
- overlap=1: history kept after a match; e.g. 1011011 with pattern 1011 gives 2 matches.
- overlap=0: on a match, fill<=0 and state<=PRIME. The completing bit cannot start the next match.
- overlap is sampled per accepted bit and may change at any time.
- din_valid=0: hist, fill, state and match_cnt hold; match=0.
- pat_load: on the next edge pat<=pat_in, len<=clamp(len_in), hist<=0, fill<=0, state<=PRIME, match<=0. match_cnt is unaffected.
  - clamp: len_in=0 or 1 → 1; len_in>MAX_LEN → MAX_LEN.
  - len=1 is legal: every bit equal to pat[0] matches once fill>=1.
- pat_load with din_valid in the same cycle: load wins and the din bit is discarded.
- match_cnt: increments by 1 per match, saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr has priority over a same-cycle increment; the result is 0.
- busy = (state==PRIME), registered.
- Reset asserted mid-stream: all state returns to reset values immediately, including any pending match pulse.

Optional Feature:
Macro SEQ_DETECT_MASK_EN.
- Defined: adds input pat_mask_in[MAX_LEN-1:0], latched with pat_load (reset value all-ones). Compare becomes ((hist_next ^ pat) & mask)[len-1:0]==0, so bits with mask 0 are don't-care.
- Not defined: no port; all len bits compared exactly. Both builds are otherwise identical.

Test Plan:
- Reset defaults: release rstn, stream 1,0,1,1 (din_valid=1) → match pulses 1 cycle after 4th bit; match_cnt=1; busy low from after 4th bit.
- Overlap: overlap=1, stream 1011011 → 2 match pulses (after bits 4 and 7), match_cnt=2; same stream with overlap=0 → 1 pulse, match_cnt=1, busy high after first match.
- Reload and gaps: pat_load pat_in=8'b1100_1010, len_in=8, stream that byte with din_valid toggling 0/1 each cycle → single match after 8th accepted bit; pat_load with din_valid=1 same cycle → that bit ignored (fill stays 0).
- Length clamp/len=1: len_in=0, pat_in=1, stream 1,1,0,1 → 3 matches; len_in=12 (MAX_LEN=8) → len reads as 8.
- Counter saturation: CNT_W=2, generate 5 matches → match_cnt stops at 3; cnt_clr coincident with a match → 0.
- Async reset mid-pattern: after 1,0,1 drive rstn low between edges → match=0, match_cnt=0, busy=1 immediately; a following 1 alone produces no match.
